uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and serialiser state encodings.
// Build option: UART_TX_PARITY_EN adds the PARITY state and even-parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_DIV_W      = 16;
    localparam int UART_FIFO_DEPTH = 4;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam uart_state_t ST_PARITY = 3'd4;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the upstream register block and the UART transmitter.
// A byte moves on any hclk edge where tx_valid and tx_ready are both high.
interface uart_tx_if;
    import uart_pkg::*;

    logic                      tx_valid;
    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO in front of the serialiser, head entry presented from storage.
// Latency: a pushed byte is visible at head_dat one edge after the push.
// Backpressure: push is ignored while full; pop is ignored while empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_dat,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] head_dat,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               count;
    logic                      do_push;
    logic                      do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Purpose: 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined) fed by a byte FIFO.
// Latency: byte accepted on edge N into an idle, empty block drives the start bit from edge N+2.
// Backpressure: tx_ready drops while the FIFO is full; bit period is div+1 hclk cycles.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
    input  logic                  hclk,
    input  logic                  hreset,
    uart_tx_if.slave              bus,
    input  logic [UART_DIV_W-1:0] div,
    output logic                  txd,
    output logic                  tx_full,
    output logic                  tx_empty
);

    uart_state_t               state;
    logic [UART_DIV_W-1:0]     div_q;
    logic [UART_DIV_W-1:0]     baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      txd_nxt;
    logic                      bit_end;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    uart_tx_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .hclk     (hclk),
        .hreset   (hreset),
        .push     (bus.tx_valid),
        .push_dat (bus.tx_data),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.tx_ready = !fifo_full;
    assign tx_full      = fifo_full;
    assign tx_empty     = fifo_empty && (state == ST_IDLE);
    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
    assign bit_end      = (baud_cnt == div_q);

    // txd is registered from the current state, so the line trails the FSM by one
    // cycle uniformly; every bit still lasts exactly div_q+1 cycles.
    always_comb begin
        txd_nxt = 1'b1;
        case (state)
            ST_START:  txd_nxt = 1'b0;
            ST_DATA:   txd_nxt = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_nxt = parity_q;
`endif
            default:   txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            txd <= txd_nxt;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_head;
                        div_q    <= div;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(fifo_head);
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + UART_DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + UART_DIV_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + UART_DIV_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + UART_DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
